hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, pipeline clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have inputs Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW (5 each): decode/execute source and E/M/W destination register indices.
REQ-003 SHALL have inputs RegwriteE, RegwriteM, RegwriteW (1 each): destination-write valid per stage.
REQ-004 SHALL have input loadE (1): the instruction in EX is a load.
REQ-005 SHALL have input redirectE (1): taken branch, jal or jalr resolved in EX.
REQ-006 SHALL have inputs icache_miss (1), meaning fetch missed this cycle, and icache_ready (1), meaning refill complete.
REQ-007 SHALL have outputs StallF, StallD, FlushD, FlushE (1 each); FlushE drives the ID/EX register clr.
REQ-008 SHALL have outputs ForwardAE, ForwardBE (2 each): 00 = register file, 01 = W result, 10 = M ALU result.
REQ-009 SHALL have outputs miss_flush (1), a pulse that tells the ICACHE to abandon its refill, and stall_cnt (16), the count of stall cycles.

Function
REQ-010 SHALL implement FSM states RUN and MISS; stall/flush outputs are combinational from state and inputs; FSM and counter update on posedge clk.
REQ-011 RUN->MISS SHALL occur when icache_miss=1 and redirectE=0.
REQ-012 MISS->RUN SHALL occur on icache_ready=1 or redirectE=1.
REQ-013 In MISS, SHALL assert StallF=1 and FlushD=1; EX/M/W keep draining.
REQ-014 Load-use (loadE, RdE!=0, RdE equals Rs1D or Rs2D) SHALL assert StallF=StallD=FlushE=1 for exactly that cycle.
REQ-015 redirectE=1 SHALL assert FlushD=FlushE=1 and suppress load-use stall and StallF/StallD in the same cycle.
REQ-016 redirectE=1 while in MISS SHALL pulse miss_flush=1 for exactly that one cycle; miss_flush=0 otherwise.
REQ-017 Priority SHALL be rst > redirectE > MISS state > load-use.
REQ-018 ForwardAE SHALL be 10 if RegwriteM, RdM!=0 and RdM==Rs1E; else 01 if RegwriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE follows the same rule on Rs2E.
REQ-019 Register x0 SHALL never cause a stall or forward.
REQ-020 stall_cnt SHALL increment in every cycle with StallF=1 and saturate at 16'hFFFF, without wrapping.
REQ-021 icache_miss and icache_ready both high in RUN SHALL still enter MISS; ready is only sampled in MISS.

Reset
REQ-022 With rst=1 at posedge clk, state SHALL become RUN and stall_cnt 0.
REQ-023 While rst=1, all stall, flush, forward and miss_flush outputs SHALL be 0, including mid-MISS; no miss_flush pulse is issued.

Configuration
REQ-024 With FORWARD_EN defined, REQ-018 SHALL apply.
REQ-025 Without FORWARD_EN, ForwardAE and ForwardBE SHALL be tied 00.
REQ-026 Without FORWARD_EN, any RAW hazard SHALL stall: Rs1D or Rs2D (non-zero) equals RdE with RegwriteE, RdM with RegwriteM, or RdW with RegwriteW. The stall asserts StallF=StallD=FlushE=1 under the same priority as load-use.

Structure
REQ-027 Package pipeline_pkg SHALL hold the FSM state enum and the ForwardAE/ForwardBE encoding constants (FWD_RF, FWD_W, FWD_M).
REQ-028 A sub-module fwd_sel SHALL compute one 2-bit forward select and SHALL be instantiated twice.

Verification
REQ-029 Load-use: loadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle, stall_cnt +1.
REQ-030 Forwarding (FORWARD_EN): RegwriteM=1, RdM=7, RegwriteW=1, RdW=7, Rs1E=7 -> ForwardAE=10. Same with RegwriteM=0 -> ForwardAE=01.
REQ-031 Miss: icache_miss for 1 cycle, icache_ready 4 cycles later -> StallF=FlushD=1 for 4 cycles, then RUN, stall_cnt=4.
REQ-032 Redirect in MISS: redirectE=1 two cycles into MISS -> miss_flush pulses 1 cycle, FlushD=FlushE=1, state RUN next cycle.
REQ-033 x0 / saturation: RdE=0, loadE=1, Rs1D=0 -> no stall. Preset stall_cnt to FFFF plus a further stall -> stays FFFF.
REQ-034 Reset mid-MISS: rst=1 -> all outputs 0, state RUN, stall_cnt 0, no miss_flush pulse.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : front-end FSM state encoding, forward-select encodings and a
//           register-match helper shared by hazard_ctrl and fwd_sel.
// Ports   : none (package).
// Config  : FORWARD_EN selects forwarding vs. stall-on-RAW in hazard_ctrl.

package pipeline_pkg;

  // Front-end fetch state: normal operation or waiting on an icache refill.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MISS = 1'b1
  } state_e;

  // Operand source select for the EX stage ALU inputs.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // memory-stage ALU result

  localparam int unsigned  CNT_W         = 16;
  localparam logic [15:0]  STALL_CNT_MAX = 16'hFFFF;

  // True when a source index names a real register written by a destination.
  // x0 is hardwired to zero, so it never matches anything.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forward source select
//
// Purpose : choose where one EX-stage operand comes from; the youngest
//           producer (M) wins over the older one (W).
// Ports   : i_rs          - EX-stage source register index
//           i_regwrite_m  - M-stage instruction writes a register
//           i_rd_m        - M-stage destination index
//           i_regwrite_w  - W-stage instruction writes a register
//           i_rd_w        - W-stage destination index
//           o_sel         - FWD_RF / FWD_W / FWD_M

import pipeline_pkg::*;

module fwd_sel (
  input  logic [4:0] i_rs,
  input  logic       i_regwrite_m,
  input  logic [4:0] i_rd_m,
  input  logic       i_regwrite_w,
  input  logic [4:0] i_rd_w,
  output logic [1:0] o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwrite_m && reg_match(i_rs, i_rd_m);
  assign w_hit_w = i_regwrite_w && reg_match(i_rs, i_rd_w);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m) begin
      o_sel = FWD_M;
    end else if (w_hit_w) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, icache-miss and redirect controller
//
// Purpose : drives fetch/decode stalls, decode/execute flushes and EX operand
//           forwarding; tracks icache misses with a RUN/MISS FSM and counts
//           fetch-stall cycles.
// Config  : FORWARD_EN defined   -> operand forwarding, stall only on load-use.
//           FORWARD_EN undefined -> forwards tied to register file, stall on
//                                   any RAW hazard against E/M/W.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           Rs1D, Rs2D                - decode source indices
//           Rs1E, Rs2E                - execute source indices
//           RdE, RdM, RdW             - E/M/W destination indices
//           RegwriteE/M/W             - destination write valid per stage
//           loadE                     - EX instruction is a load
//           redirectE                 - control transfer resolved in EX
//           icache_miss, icache_ready - fetch missed / refill complete
//           StallF, StallD            - hold fetch / decode registers
//           FlushD, FlushE            - clear IF/ID and ID/EX registers
//           ForwardAE, ForwardBE      - EX operand source selects
//           miss_flush                - tell icache to abandon its refill
//           stall_cnt                 - saturating count of StallF cycles

import pipeline_pkg::*;

module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegwriteE,
  input  logic        RegwriteM,
  input  logic        RegwriteW,
  input  logic        loadE,
  input  logic        redirectE,
  input  logic        icache_miss,
  input  logic        icache_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        miss_flush,
  output logic [15:0] stall_cnt
);

  state_e      r_state;
  state_e      w_next_state;
  logic [15:0] r_stall_cnt;

  logic        w_load_use;
  logic        w_raw;
  logic        w_hazard;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic [1:0]  w_fwd_a_sel;
  logic [1:0]  w_fwd_b_sel;
  logic        w_unused;

  fwd_sel u_fwd_a (
    .i_rs         (Rs1E),
    .i_regwrite_m (RegwriteM),
    .i_rd_m       (RdM),
    .i_regwrite_w (RegwriteW),
    .i_rd_w       (RdW),
    .o_sel        (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_rs         (Rs2E),
    .i_regwrite_m (RegwriteM),
    .i_rd_m       (RdM),
    .i_regwrite_w (RegwriteW),
    .i_rd_w       (RdW),
    .o_sel        (w_fwd_b)
  );

  // A load result is not available until after M, so a dependent decode
  // instruction must wait one cycle even with forwarding.
  assign w_load_use = loadE && (reg_match(Rs1D, RdE) || reg_match(Rs2D, RdE));

`ifdef FORWARD_EN
  assign w_raw       = 1'b0;
  assign w_fwd_a_sel = w_fwd_a;
  assign w_fwd_b_sel = w_fwd_b;
  assign w_unused    = RegwriteE;
`else
  // Without forwarding, decode waits until no in-flight stage still has a
  // pending write to either of its sources.
  assign w_raw = (RegwriteE && (reg_match(Rs1D, RdE) || reg_match(Rs2D, RdE))) ||
                 (RegwriteM && (reg_match(Rs1D, RdM) || reg_match(Rs2D, RdM))) ||
                 (RegwriteW && (reg_match(Rs1D, RdW) || reg_match(Rs2D, RdW)));
  assign w_fwd_a_sel = FWD_RF;
  assign w_fwd_b_sel = FWD_RF;
  assign w_unused    = ^{w_fwd_a, w_fwd_b};
`endif

  assign w_hazard = w_load_use || w_raw;

  // Priority chain: reset, redirect, outstanding miss, data hazard.
  always_comb begin
    w_next_state = r_state;
    StallF       = 1'b0;
    StallD       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    miss_flush   = 1'b0;
    ForwardAE    = FWD_RF;
    ForwardBE    = FWD_RF;

    if (rst) begin
      w_next_state = RUN;
    end else begin
      ForwardAE = w_fwd_a_sel;
      ForwardBE = w_fwd_b_sel;
      if (redirectE) begin
        // Wrong-path fetch is discarded; any refill in flight is for the
        // wrong path too, so the icache is told to drop it.
        FlushD       = 1'b1;
        FlushE       = 1'b1;
        miss_flush   = (r_state == MISS);
        w_next_state = RUN;
      end else if (r_state == MISS) begin
        // Fetch holds and decode gets bubbles; EX onward keeps draining.
        StallF = 1'b1;
        FlushD = 1'b1;
        if (icache_ready) begin
          w_next_state = RUN;
        end
      end else begin
        if (w_hazard) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        // icache_ready is ignored here: a miss reported in RUN always
        // spends at least one cycle in MISS.
        if (icache_miss) begin
          w_next_state = MISS;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (StallF && (r_stall_cnt != STALL_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegwriteE, RegwriteM, RegwriteW;
  logic        loadE, redirectE, icache_miss, icache_ready;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        miss_flush;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegwriteE    (RegwriteE),
    .RegwriteM    (RegwriteM),
    .RegwriteW    (RegwriteW),
    .loadE        (loadE),
    .redirectE    (redirectE),
    .icache_miss  (icache_miss),
    .icache_ready (icache_ready),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .miss_flush   (miss_flush),
    .stall_cnt    (stall_cnt)
  );

  // ctl fields are {StallF, StallD, FlushD, FlushE}; _f with forwarding,
  // _n without. fa/fb are the forwarding-build selects.
  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, loade, redir;
    logic [3:0] ctl_f, ctl_n;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t        vecs[16];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;
  logic [15:0] base_cnt;

  function automatic vec_t mk(
    input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
    input logic rwe, rwm, rww, loade, redir,
    input logic [3:0] ctl_f, ctl_n,
    input logic [1:0] fa, fb);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.loade = loade; v.redir = redir;
    v.ctl_f = ctl_f; v.ctl_n = ctl_n; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Checks all outputs against expectations and advances the bench's own
  // stall-count expectation by this cycle's expected StallF.
  task automatic check(input string nm, input logic [3:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic mf);
    cmp({nm, ".ctl"}, {12'd0, StallF, StallD, FlushD, FlushE}, {12'd0, ctl});
    cmp({nm, ".fwd"}, {12'd0, ForwardAE, ForwardBE}, {12'd0, fa, fb});
    cmp({nm, ".miss_flush"}, {15'd0, miss_flush}, {15'd0, mf});
    cmp({nm, ".stall_cnt"}, stall_cnt, exp_cnt);
    if (ctl[3] && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegwriteE = 0; RegwriteM = 0; RegwriteW = 0;
    loadE = 0; redirectE = 0; icache_miss = 0; icache_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    loadE = 1; RegwriteE = 1; RdE = 5'd5; Rs1D = 5'd5;
  endtask

  initial begin
    vec_t       v;
    logic [3:0] ectl;
    logic [1:0] efa, efb;

    //             rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww ld rd  ctl_f    ctl_n    fa     fb
    vecs[0]  = mk(0,  0,  0,  0,  0, 0,  0,  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00);
    vecs[1]  = mk(5,  0,  0,  0,  5, 0,  0,  1, 0, 0, 1, 0, 4'b1101, 4'b1101, 2'b00, 2'b00);
    vecs[2]  = mk(3,  9,  0,  0,  9, 0,  0,  1, 0, 0, 1, 0, 4'b1101, 4'b1101, 2'b00, 2'b00);
    vecs[3]  = mk(0,  0,  0,  0,  0, 0,  0,  1, 0, 0, 1, 0, 4'b0000, 4'b0000, 2'b00, 2'b00);
    vecs[4]  = mk(0,  0,  7,  0,  0, 7,  7,  0, 1, 1, 0, 0, 4'b0000, 4'b0000, 2'b10, 2'b00);
    vecs[5]  = mk(0,  0,  7,  0,  0, 7,  7,  0, 0, 1, 0, 0, 4'b0000, 4'b0000, 2'b01, 2'b00);
    vecs[6]  = mk(0,  0, 12, 12,  0, 12, 3,  0, 1, 1, 0, 0, 4'b0000, 4'b0000, 2'b10, 2'b10);
    vecs[7]  = mk(0,  0,  4,  3,  0, 4,  3,  0, 1, 1, 0, 0, 4'b0000, 4'b0000, 2'b10, 2'b01);
    vecs[8]  = mk(0,  0,  0,  0,  0, 0,  0,  0, 1, 1, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00);
    vecs[9]  = mk(0,  0,  4,  4,  0, 4,  4,  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00);
    vecs[10] = mk(6,  0,  0,  0,  6, 0,  0,  1, 0, 0, 0, 0, 4'b0000, 4'b1101, 2'b00, 2'b00);
    vecs[11] = mk(0,  8,  0,  0,  0, 8,  0,  0, 1, 0, 0, 0, 4'b0000, 4'b1101, 2'b00, 2'b00);
    vecs[12] = mk(10, 0,  0,  0,  0, 0, 10,  0, 0, 1, 0, 0, 4'b0000, 4'b1101, 2'b00, 2'b00);
    vecs[13] = mk(5,  0,  0,  0,  5, 0,  0,  1, 0, 0, 1, 1, 4'b0011, 4'b0011, 2'b00, 2'b00);
    vecs[14] = mk(0,  0,  7,  0,  0, 7,  0,  0, 1, 0, 0, 1, 4'b0011, 4'b0011, 2'b10, 2'b00);
    vecs[15] = mk(6,  0,  0,  0,  6, 0,  0,  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00);

    // Reset: outputs stay low even with a hazard and a miss presented.
    rst = 1; idle(); exp_cnt = 16'd0;
    tick(); tick();
    set_load_use(); icache_miss = 1;
    @(negedge clk); check("rst_hold", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); rst = 0; idle();
    @(negedge clk); check("rst_release", 4'b0000, 2'b00, 2'b00, 1'b0);

    // Table-driven combinational vectors, all in RUN.
    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      tick(); idle();
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      RegwriteE = v.rwe; RegwriteM = v.rwm; RegwriteW = v.rww;
      loadE = v.loade; redirectE = v.redir;
`ifdef FORWARD_EN
      ectl = v.ctl_f; efa = v.fa; efb = v.fb;
`else
      ectl = v.ctl_n; efa = 2'b00; efb = 2'b00;
`endif
      @(negedge clk); check($sformatf("vec%0d", i), ectl, efa, efb, 1'b0);
    end

    // Miss for one cycle, ready four MISS cycles later.
    tick(); idle(); icache_miss = 1; base_cnt = exp_cnt;
    @(negedge clk); check("miss_enter", 4'b0000, 2'b00, 2'b00, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick(); idle(); if (k == 4) icache_ready = 1;
      @(negedge clk); check($sformatf("miss_c%0d", k), 4'b1010, 2'b00, 2'b00, 1'b0);
    end
    tick(); idle();
    @(negedge clk); check("miss_exit", 4'b0000, 2'b00, 2'b00, 1'b0);
    cmp("miss_cnt_plus4", stall_cnt, base_cnt + 16'd4);

    // Redirect two cycles into MISS.
    tick(); idle(); icache_miss = 1;
    @(negedge clk); check("rdm_enter", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("rdm_c1", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("rdm_c2", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle(); redirectE = 1;
    @(negedge clk); check("rdm_redirect", 4'b0011, 2'b00, 2'b00, 1'b1);
    tick(); idle();
    @(negedge clk); check("rdm_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    // Miss and ready together in RUN still enter MISS.
    tick(); idle(); icache_miss = 1; icache_ready = 1;
    @(negedge clk); check("mr_enter", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("mr_c1", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle(); icache_ready = 1;
    @(negedge clk); check("mr_c2", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("mr_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    // Redirect wins over a miss reported in RUN: no MISS entry, no pulse.
    tick(); idle(); icache_miss = 1; redirectE = 1;
    @(negedge clk); check("rr_redirect", 4'b0011, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("rr_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    // MISS outranks load-use.
    tick(); idle(); icache_miss = 1;
    @(negedge clk); check("ml_enter", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); idle(); set_load_use();
    @(negedge clk); check("ml_c1", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle(); icache_ready = 1;
    @(negedge clk); check("ml_c2", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("ml_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    // Reset mid-MISS, with a redirect present: no pulse, all outputs low.
    tick(); idle(); icache_miss = 1;
    @(negedge clk); check("rm_enter", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk); check("rm_c1", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); idle(); rst = 1; redirectE = 1; set_load_use();
    @(negedge clk); check("rm_reset", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); rst = 0; idle(); exp_cnt = 16'd0;
    @(negedge clk); check("rm_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    // Saturation: a long MISS drives the counter to its ceiling.
    tick(); idle(); icache_miss = 1;
    @(negedge clk); check("sat_enter", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    @(negedge clk);
    cmp("sat_first", stall_cnt, 16'd0);
    repeat (65534) @(negedge clk);
    cmp("sat_fffe", stall_cnt, 16'hFFFE);
    @(negedge clk);
    cmp("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (2) @(negedge clk);
    cmp("sat_hold", stall_cnt, 16'hFFFF);
    cmp("sat_stallf", {15'd0, StallF}, 16'd1);
    tick(); idle(); icache_ready = 1;
    @(negedge clk);
    cmp("sat_ready", stall_cnt, 16'hFFFF);
    tick(); idle();
    @(negedge clk);
    cmp("sat_run_stallf", {15'd0, StallF}, 16'd0);
    cmp("sat_run_cnt", stall_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
